uart_rx_os16: RTL

- UART receiver that consumes the 16x-oversample clock Uart_CLK from the UART clock divider.
- Uart_CLK toggles every 163 Sys_CLK cycles, giving a period of 326 Sys_CLK cycles (≈16×9600 baud at 50 MHz).
- The block runs entirely in the Sys_CLK domain and turns each rising edge of Uart_CLK into a one-cycle sample tick.
- It deserialises 8N1 frames (optionally 8E1) from the asynchronous RXD pin and presents a byte with a one-cycle valid strobe to downstream logic.

---
 rtl/uart_rx_os16.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampled from Uart_CLK ticks, 8N1 framing.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = 7
) (
  input  logic                 Sys_CLK,
  input  logic                 Sys_RST,
  input  logic                 Uart_CLK,
  input  logic                 Uart_RXD,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic                 Rx_FrameErr,
  output logic                 Rx_ParityErr,
  output logic                 Rx_Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [3:0] CNT_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 rxd_q1, rxd_q2;
  logic                 uclk_q;
  logic                 rxd_s;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign rxd_s = rxd_q2;
  assign tick  = Uart_CLK & ~uclk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            bitn_d  = '0;
            state_d = rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            if (bitn_q == BIT_LAST) begin
              bitn_d  = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bitn_d = bitn_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rxd_s;
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = ^{shift_q, par_q};
`endif
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        // One frame error per low period; wait for the line to recover.
        S_BREAK: begin
          if (rxd_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bitn_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      rxd_q1  <= 1'b1;
      rxd_q2  <= 1'b1;
      uclk_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      rxd_q1  <= Uart_RXD;
      rxd_q2  <= rxd_q1;
      uclk_q  <= Uart_CLK;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Rx_Data      = data_q;
  assign Rx_Valid     = valid_q;
  assign Rx_FrameErr  = ferr_q;
  assign Rx_ParityErr = perr_q;
  assign Rx_Busy      = (state_q != S_IDLE);

endmodule
